// File: rtl/aes_256_arbiter_if.sv
// Requester and response bundle for the aes_256 arbiter.
// Both directions use valid/ready handshakes.
interface aes_256_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_state;
  logic [NUM_REQ*256-1:0] req_key;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [127:0]           rsp_data;

  modport master (
    output req_valid, req_state, req_key,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_state, req_key,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/aes_256_arbiter.sv
// Round-robin front end sharing one pipelined aes_256 core.
// Results are tagged with the issuing id and buffered under credit.
module aes_256_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int LATENCY    = 29,
  parameter int FIFO_DEPTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_256_arbiter_if.slave bus,
  output logic [127:0]   core_state,
  output logic [255:0]   core_key,
  input  logic [127:0]   core_out,
  output logic           busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int PW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic                run_q;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     idx;
  logic                found;
  logic                credit_ok;
  logic                issue;
  logic [LATENCY-1:0]  tv;
  logic [ID_W-1:0]     tid [LATENCY];
  logic [IW-1:0]       inflight;
  logic [CW-1:0]       count;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [ID_W+127:0]   mem [FIFO_DEPTH];
  logic                push;
  logic                pop;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + 32'(k)) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Reserve a FIFO slot for every block before it enters the core
  assign credit_ok = (32'(count) + 32'(inflight))
                     < 32'(FIFO_DEPTH);
  assign issue = run_q & found & credit_ok;

  always_comb begin
    bus.req_ready = '0;
    if (issue) bus.req_ready[grant] = 1'b1;
  end

  assign core_state = issue ?
    bus.req_state[32'(grant)*128 +: 128] : '0;
  assign core_key = issue ?
    bus.req_key[32'(grant)*256 +: 256] : '0;

  assign push = tv[LATENCY-1];
  assign pop  = bus.rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      ptr      <= '0;
      tv       <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      run_q <= 1'b1;
      if (issue)
        ptr <= (32'(grant) == NUM_REQ - 1) ?
               '0 : grant + 1'b1;
      tv <= {tv[LATENCY-2:0], issue};
      inflight <= inflight + IW'(issue) - IW'(push);
      count <= count + CW'(push) - CW'(pop);
      if (push)
        wr_ptr <= (32'(wr_ptr) == FIFO_DEPTH - 1) ?
                  '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (32'(rd_ptr) == FIFO_DEPTH - 1) ?
                  '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++)
        tid[k] <= '0;
    end else begin
      tid[0] <= grant;
      for (int k = 1; k < LATENCY; k++)
        tid[k] <= tid[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {tid[LATENCY-1], core_out};
  end

  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_id    = mem[rd_ptr][ID_W+127:128];
  assign bus.rsp_data  = mem[rd_ptr][127:0];
  assign busy = (inflight != '0) | (count != '0);
endmodule

// File: tb/tb_aes_256_arbiter.sv
// Bench for aes_256_arbiter: stand-in pipelined core, scoreboards,
// a vector table and hand-written multi-cycle sequences.
module tb_aes_256_arbiter;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int LAT = 29;

  localparam logic [127:0] V1S =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] V1K =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C1 =
    128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] V2S =
    128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] V2K =
    256'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe;
  localparam logic [127:0] C2 =
    128'h1a6e6c2c662e7da6501ffb62bc9e93f3;

  // Stand-in cipher: known AES-256 vectors, otherwise a keyed mix
  function automatic logic [127:0] fcore(
    input logic [127:0] s, input logic [255:0] k);
    if (s == V1S && k == V1K) return C1;
    if (s == V2S && k == V2K) return C2;
    return s ^ k[127:0] ^ k[255:128]
           ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  logic [127:0] cs_a, cs_b, co_a, co_b;
  logic [255:0] ck_a, ck_b;
  logic busy_a, busy_b;

  aes_256_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW)) ba ();
  aes_256_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW)) bb ();

  aes_256_arbiter #(
    .NUM_REQ(NR), .ID_W(IDW),
    .LATENCY(LAT), .FIFO_DEPTH(32)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(ba),
    .core_state(cs_a), .core_key(ck_a),
    .core_out(co_a), .busy(busy_a)
  );

  aes_256_arbiter #(
    .NUM_REQ(NR), .ID_W(IDW),
    .LATENCY(LAT), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(bb),
    .core_state(cs_b), .core_key(ck_b),
    .core_out(co_b), .busy(busy_b)
  );

  logic [127:0] pa [LAT];
  logic [127:0] pb [LAT];
  always_ff @(posedge clk) begin
    pa[0] <= fcore(cs_a, ck_a);
    pb[0] <= fcore(cs_b, ck_b);
    for (int k = 1; k < LAT; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end
  assign co_a = pa[LAT-1];
  assign co_b = pb[LAT-1];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic [IDW+127:0] qa[$];
  logic [IDW+127:0] qb[$];

  always @(negedge clk) begin
    logic [IDW+127:0] e;
    if (rst_a_n) begin
      for (int i = 0; i < NR; i++)
        if (ba.req_valid[i] && ba.req_ready[i]) begin
          qa.push_back({IDW'(i),
            fcore(ba.req_state[i*128 +: 128],
                  ba.req_key[i*256 +: 256])});
          chk("a_core_state", 256'(cs_a),
              256'(ba.req_state[i*128 +: 128]));
          chk("a_credit", 256'(qa.size() <= 32), 256'(1));
        end
      if (ba.rsp_valid && ba.rsp_ready) begin
        chk("a_rsp_expected", 256'(qa.size() > 0), 256'(1));
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk("a_rsp", 256'({ba.rsp_id, ba.rsp_data}),
              256'(e));
        end
      end
    end
    if (rst_b_n) begin
      for (int i = 0; i < NR; i++)
        if (bb.req_valid[i] && bb.req_ready[i]) begin
          qb.push_back({IDW'(i),
            fcore(bb.req_state[i*128 +: 128],
                  bb.req_key[i*256 +: 256])});
          chk("b_credit", 256'(qb.size() <= 4), 256'(1));
        end
      if (bb.rsp_valid && bb.rsp_ready) begin
        chk("b_rsp_expected", 256'(qb.size() > 0), 256'(1));
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk("b_rsp", 256'({bb.rsp_id, bb.rsp_data}),
              256'(e));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int           r;
    logic [127:0] s;
    logic [255:0] k;
    logic [127:0] exp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[4];
    int   n, g, prev, nb, k;
    int   cnt[NR];
    logic [127:0] s3;
    logic [255:0] k3;

    s3 = 128'hdeadbeef0badf00dcafebabe12345678;
    k3 = {8{32'h5a3c9611}};
    tbl[0] = '{0, V1S, V1K, C1};
    tbl[1] = '{1, V2S, V2K, C2};
    tbl[2] = '{3, V1S, V1K, C1};
    tbl[3] = '{2, s3, k3, fcore(s3, k3)};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ba.req_valid = '1;
    ba.req_state = {NR{V1S}};
    ba.req_key   = {NR{V1K}};
    ba.rsp_ready = 1'b1;
    bb.req_valid = '0;
    bb.req_state = '0;
    bb.req_key   = '0;
    bb.rsp_ready = 1'b0;
    #12;
    chk("rst_ready", 256'(ba.req_ready), 256'(0));
    chk("rst_rsp_valid", 256'(ba.rsp_valid), 256'(0));
    chk("rst_busy", 256'(busy_a), 256'(0));
    chk("rst_core_state", 256'(cs_a), 256'(0));
    chk("rst_core_key", ck_a, 256'(0));
    ba.req_valid = '0;
    ba.rsp_ready = 1'b0;
    cyc();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    cyc();
    cyc();

    for (int j = 0; j < 4; j++) begin
      ba.req_state[tbl[j].r*128 +: 128] = tbl[j].s;
      ba.req_key[tbl[j].r*256 +: 256]   = tbl[j].k;
      ba.req_valid = NR'(1) << tbl[j].r;
      @(negedge clk);
      chk("tbl_ready", 256'(ba.req_ready),
          256'(NR'(1) << tbl[j].r));
      cyc();
      ba.req_valid = '0;
      n = 0;
      while (!ba.rsp_valid && n < 100) begin
        cyc();
        n++;
      end
      chk("tbl_latency", 256'(n), 256'(LAT));
      chk("tbl_id", 256'(ba.rsp_id), 256'(tbl[j].r));
      chk("tbl_data", 256'(ba.rsp_data), 256'(tbl[j].exp));
      ba.rsp_ready = 1'b1;
      cyc();
      ba.rsp_ready = 1'b0;
      chk("tbl_empty", 256'(ba.rsp_valid), 256'(0));
      chk("tbl_idle", 256'(busy_a), 256'(0));
    end

    // back-to-back issue from two requesters
    ba.rsp_ready = 1'b1;
    ba.req_state[1*128 +: 128] = V2S;
    ba.req_key[1*256 +: 256]   = V2K;
    ba.req_state[2*128 +: 128] = V1S;
    ba.req_key[2*256 +: 256]   = V1K;
    ba.req_valid = 4'b0010;
    cyc();
    ba.req_valid = 4'b0100;
    cyc();
    ba.req_valid = '0;
    n = 0;
    @(negedge clk);
    while (!ba.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_id", 256'(ba.rsp_id), 256'(1));
    chk("b2b_first_data", 256'(ba.rsp_data), 256'(C2));
    @(negedge clk);
    chk("b2b_second_valid", 256'(ba.rsp_valid), 256'(1));
    chk("b2b_second_id", 256'(ba.rsp_id), 256'(2));
    chk("b2b_second_data", 256'(ba.rsp_data), 256'(C1));
    cyc();

    // round robin, all requesters valid
    for (int i = 0; i < NR; i++) begin
      ba.req_state[i*128 +: 128] =
        {4{32'(i) + 32'ha5a50000}};
      ba.req_key[i*256 +: 256] = {8{32'(i * 7 + 3)}};
      cnt[i] = 0;
    end
    ba.req_valid = '1;
    prev = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      g = -1;
      for (int i = 0; i < NR; i++)
        if (ba.req_ready[i]) g = i;
      chk("rr_onehot", 256'($onehot(ba.req_ready)), 256'(1));
      if (c > 0)
        chk("rr_order", 256'(g), 256'((prev + 1) % NR));
      if (g >= 0) cnt[g]++;
      prev = g;
    end
    cyc();
    ba.req_valid = '0;
    for (int i = 0; i < NR; i++)
      chk("rr_fair", 256'(cnt[i]), 256'(10));
    n = 0;
    while (busy_a && n < 200) begin
      cyc();
      n++;
    end
    chk("rr_drained", 256'(busy_a), 256'(0));

    // back-pressure on the 4-deep instance
    for (int i = 0; i < NR; i++) begin
      bb.req_state[i*128 +: 128] = {4{32'(i) + 32'h1000}};
      bb.req_key[i*256 +: 256]   = {8{32'(i) + 32'h77}};
    end
    bb.req_valid = '1;
    nb = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      nb += $countones(bb.req_valid & bb.req_ready);
    end
    chk("bp_issues", 256'(nb), 256'(4));
    chk("bp_stalled", 256'(bb.req_ready), 256'(0));
    chk("bp_full_valid", 256'(bb.rsp_valid), 256'(1));
    cyc();
    bb.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_no_issue", 256'(bb.req_ready), 256'(0));
    k = 0;
    while (bb.req_ready == '0 && k < 6) begin
      @(negedge clk);
      k++;
    end
    chk("bp_resume", 256'(k), 256'(1));
    cyc();
    bb.req_valid = '0;
    n = 0;
    while (busy_b && n < 200) begin
      cyc();
      n++;
    end
    chk("bp_drained", 256'(busy_b), 256'(0));

    // reset while three blocks are in flight
    ba.rsp_ready = 1'b0;
    ba.req_valid = 4'b0111;
    cyc();
    cyc();
    cyc();
    ba.req_valid = '0;
    repeat (10) cyc();
    #2;
    rst_a_n = 1'b0;
    #1;
    qa.delete();
    chk("mid_rst_busy", 256'(busy_a), 256'(0));
    chk("mid_rst_rsp_valid", 256'(ba.rsp_valid), 256'(0));
    cyc();
    cyc();
    rst_a_n = 1'b1;
    ba.rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ba.rsp_valid || busy_a) n++;
    end
    chk("mid_rst_silent", 256'(n), 256'(0));
    cyc();

    // push and pop in the same cycle with one entry held
    ba.rsp_ready = 1'b0;
    ba.req_state[0 +: 128] = V1S;
    ba.req_key[0 +: 256]   = V1K;
    ba.req_valid = 4'b0001;
    cyc();
    ba.req_state[0 +: 128] = V2S;
    ba.req_key[0 +: 256]   = V2K;
    cyc();
    ba.req_valid = '0;
    n = 0;
    while (!ba.rsp_valid && n < 100) begin
      cyc();
      n++;
    end
    chk("pp_head", 256'(ba.rsp_data), 256'(C1));
    ba.rsp_ready = 1'b1;
    cyc();
    ba.rsp_ready = 1'b0;
    chk("pp_valid", 256'(ba.rsp_valid), 256'(1));
    chk("pp_next_id", 256'(ba.rsp_id), 256'(0));
    chk("pp_next_data", 256'(ba.rsp_data), 256'(C2));
    cyc();
    chk("pp_hold", 256'(ba.rsp_valid), 256'(1));
    ba.rsp_ready = 1'b1;
    cyc();
    ba.rsp_ready = 1'b0;
    chk("pp_count_one", 256'(ba.rsp_valid), 256'(0));
    chk("pp_idle", 256'(busy_a), 256'(0));

    chk("sb_a_empty", 256'(qa.size()), 256'(0));
    chk("sb_b_empty", 256'(qb.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
